// File: rtl/bitonic_sort_scheduler_if.sv
// Handshake bundle for the shared sorter scheduler: requester side, sorter side, response side, status.
interface bitonic_sort_scheduler_if #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int FW  = DEPTH * WIDTH;
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*FW-1:0] req_data;
  logic                  sort_valid_in;
  logic [FW-1:0]         sort_seq_in;
  logic                  sort_valid_out;
  logic [FW-1:0]         sort_seq_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [FW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic                  err_orphan;

  modport master (
    input  req_valid, req_data, sort_valid_out, sort_seq_out, rsp_ready,
    output req_ready, sort_valid_in, sort_seq_in, rsp_valid, rsp_data, rsp_id, busy, err_orphan
  );
  modport slave (
    output req_valid, req_data, sort_valid_out, sort_seq_out, rsp_ready,
    input  req_ready, sort_valid_in, sort_seq_in, rsp_valid, rsp_data, rsp_id, busy, err_orphan
  );
endinterface

// File: rtl/bitonic_sort_scheduler.sv
// Round-robin frame scheduler in front of one fixed-latency pipelined sorter; tags ride a FIFO
// alongside the sorter and credits reserve a result slot for every frame issued.
module bitonic_sort_scheduler #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int SORT_LAT   = 10,
  parameter int RESP_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  bitonic_sort_scheduler_if.master bus
);
  localparam int FW     = DEPTH * WIDTH;
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int CW     = $clog2(RESP_DEPTH + 1);
  localparam int TDEPTH = SORT_LAT + 2;
  localparam int TAW    = $clog2(TDEPTH);
  localparam int TCW    = $clog2(TDEPTH + 1);
  localparam int RAW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int DCW    = $clog2(SORT_LAT + 2);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [DCW-1:0]     drain_q;
  logic               sv_in_q;
  logic [FW-1:0]      seq_in_q;
  logic [IDW-1:0]     tag_mem_q [TDEPTH];
  logic [TAW-1:0]     twr_q, trd_q;
  logic [TCW-1:0]     tcnt_q, tcnt_d;
  logic [FW-1:0]      rdata_q [RESP_DEPTH];
  logic [IDW-1:0]     rid_q [RESP_DEPTH];
  logic [RAW-1:0]     rwr_q, rrd_q;
  logic [CW-1:0]      rcnt_q, rcnt_d;
  logic               err_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gidx;
  logic               draining, credit_ok, accept, ret, orphan, pop;
  int                 idx;

  function automatic logic [TAW-1:0] tinc(input logic [TAW-1:0] p);
    return (p == TAW'(TDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAW-1:0] rinc(input logic [RAW-1:0] p);
    return (p == RAW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign draining  = (drain_q != '0);
  // tag-FIFO occupancy is the in-flight count: pushed on accept, popped on retire
  assign credit_ok = (int'(rcnt_q) + int'(tcnt_q)) < RESP_DEPTH;

  // walk from the pointer downward so the closest requester is the last (winning) assignment
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = 0;
    if (!draining && credit_ok) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.req_valid[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
        end
      end
    end
  end

  assign accept = |grant;
  assign ret    = bus.sort_valid_out && !draining && (tcnt_q != '0);
  assign orphan = bus.sort_valid_out && !draining && (tcnt_q == '0);
  assign pop    = (rcnt_q != '0) && bus.rsp_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    tcnt_d = tcnt_q + TCW'(accept) - TCW'(ret);
    rcnt_d = rcnt_q + CW'(ret) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      drain_q  <= DCW'(SORT_LAT + 1);
      sv_in_q  <= 1'b0;
      seq_in_q <= '0;
      twr_q    <= '0;
      trd_q    <= '0;
      tcnt_q   <= '0;
      rwr_q    <= '0;
      rrd_q    <= '0;
      rcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      if (draining) drain_q <= drain_q - 1'b1;
      sv_in_q  <= accept;
      seq_in_q <= accept ? bus.req_data[int'(gidx)*FW +: FW] : '0;
      if (accept) twr_q <= tinc(twr_q);
      if (ret)    trd_q <= tinc(trd_q);
      tcnt_q   <= tcnt_d;
      if (ret)    rwr_q <= rinc(rwr_q);
      if (pop)    rrd_q <= rinc(rrd_q);
      rcnt_q   <= rcnt_d;
      if (orphan) err_q <= 1'b1;
    end
  end

  // storage only; validity is carried entirely by the reset pointers and counts
  always_ff @(posedge clk) begin
    if (accept) tag_mem_q[twr_q] <= gidx;
    if (ret) begin
      rdata_q[rwr_q] <= bus.sort_seq_out;
      rid_q[rwr_q]   <= tag_mem_q[trd_q];
    end
  end

  assign bus.req_ready     = grant;
  assign bus.sort_valid_in = sv_in_q;
  assign bus.sort_seq_in   = seq_in_q;
  assign bus.rsp_valid     = (rcnt_q != '0);
  assign bus.rsp_data      = bus.rsp_valid ? rdata_q[rrd_q] : '0;
  assign bus.rsp_id        = bus.rsp_valid ? rid_q[rrd_q] : '0;
  assign bus.busy          = (tcnt_q != '0) || (rcnt_q != '0) || sv_in_q;
  assign bus.err_orphan    = err_q;
endmodule
